// File: rtl/vga_timing_if.sv
// vga_timing_if: raster sync bundle between the VGA timing generator (master)
// and its consumers such as the sprite position counters (slave).
// The consumer side owns 'enable'; everything else flows from the generator.
interface vga_timing_if;

  logic       enable;
  logic       pixel_clk;
  logic       h_sync;
  logic       v_sync;
  logic [9:0] h_pos;
  logic [9:0] v_pos;
  logic       active_video;
  logic       line_start;
  logic       frame_start;

  modport master (
    input  enable,
    output pixel_clk,
    output h_sync,
    output v_sync,
    output h_pos,
    output v_pos,
    output active_video,
    output line_start,
    output frame_start
  );

  modport slave (
    output enable,
    input  pixel_clk,
    input  h_sync,
    input  v_sync,
    input  h_pos,
    input  v_pos,
    input  active_video,
    input  line_start,
    input  frame_start
  );

endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 Hz raster timing generator.
// A clock divider produces one pixel tick every CLK_DIV system clocks. A
// horizontal FSM walks ACTIVE/FRONT/SYNC/BACK once per line and a vertical
// FSM does the same once per frame, stepping only when the line wraps.
// All level outputs are registered but decoded from the next counter/state
// values, so they always line up with the h_pos/v_pos shown in the same clk.
// Totals must not exceed 1024, every porch/sync width must be nonzero and
// CLK_DIV must be even and at least 2.
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  vga_timing_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int               DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  localparam logic [9:0] H_FRONT_START = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYNC_START  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_BACK_START  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST        = 10'(H_TOTAL - 1);

  localparam logic [9:0] V_FRONT_START = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYNC_START  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_BACK_START  = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST        = 10'(V_TOTAL - 1);

  typedef enum logic [1:0] {
    PH_ACTIVE,
    PH_FRONT,
    PH_SYNC,
    PH_BACK
  } phase_t;

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic             tick;

  logic [9:0] h_pos_q;
  logic [9:0] h_pos_d;
  logic [9:0] v_pos_q;
  logic [9:0] v_pos_d;
  logic       line_wrap;
  logic       frame_wrap;

  phase_t h_state_q;
  phase_t h_state_d;
  phase_t v_state_q;
  phase_t v_state_d;

  // Pixel divider: counts system clocks and flags the last one of each pixel.
  always_comb begin
    tick  = 1'b0;
    div_d = div_q;
    if (vga.enable) begin
      if (div_q == DIV_LAST) begin
        tick  = 1'b1;
        div_d = '0;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  // Horizontal counter and phase FSM, stepped once per pixel tick.
  always_comb begin
    line_wrap = (h_pos_q == H_LAST);
    h_pos_d   = h_pos_q;
    h_state_d = h_state_q;
    if (tick) begin
      h_pos_d = line_wrap ? '0 : h_pos_q + 10'd1;
      case (h_state_q)
        PH_ACTIVE: if (h_pos_d == H_FRONT_START) h_state_d = PH_FRONT;
        PH_FRONT:  if (h_pos_d == H_SYNC_START)  h_state_d = PH_SYNC;
        PH_SYNC:   if (h_pos_d == H_BACK_START)  h_state_d = PH_BACK;
        PH_BACK:   if (line_wrap)                h_state_d = PH_ACTIVE;
        default:                                 h_state_d = PH_ACTIVE;
      endcase
    end
  end

  // Vertical counter and phase FSM, stepped only on the tick that wraps a line.
  always_comb begin
    frame_wrap = (v_pos_q == V_LAST);
    v_pos_d    = v_pos_q;
    v_state_d  = v_state_q;
    if (tick && line_wrap) begin
      v_pos_d = frame_wrap ? '0 : v_pos_q + 10'd1;
      case (v_state_q)
        PH_ACTIVE: if (v_pos_d == V_FRONT_START) v_state_d = PH_FRONT;
        PH_FRONT:  if (v_pos_d == V_SYNC_START)  v_state_d = PH_SYNC;
        PH_SYNC:   if (v_pos_d == V_BACK_START)  v_state_d = PH_BACK;
        PH_BACK:   if (frame_wrap)               v_state_d = PH_ACTIVE;
        default:                                 v_state_d = PH_ACTIVE;
      endcase
    end
  end

  // State registers; with enable low every next value equals the current one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q     <= '0;
      h_pos_q   <= '0;
      v_pos_q   <= '0;
      h_state_q <= PH_ACTIVE;
      v_state_q <= PH_ACTIVE;
    end else begin
      div_q     <= div_d;
      h_pos_q   <= h_pos_d;
      v_pos_q   <= v_pos_d;
      h_state_q <= h_state_d;
      v_state_q <= v_state_d;
    end
  end

  // Output registers decoded from next values so they match the counters shown.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vga.pixel_clk    <= 1'b0;
      vga.h_sync       <= ~SYNC_POL;
      vga.v_sync       <= ~SYNC_POL;
      vga.active_video <= 1'b1;
      vga.line_start   <= 1'b0;
      vga.frame_start  <= 1'b0;
    end else begin
      vga.line_start  <= tick & line_wrap;
      vga.frame_start <= tick & line_wrap & frame_wrap;
      if (vga.enable) begin
        vga.pixel_clk    <= (div_d < DIV_HALF);
        vga.h_sync       <= (h_state_d == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
        vga.v_sync       <= (v_state_d == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
        vga.active_video <= (h_state_d == PH_ACTIVE) && (v_state_d == PH_ACTIVE);
      end
    end
  end

  assign vga.h_pos = h_pos_q;
  assign vga.v_pos = v_pos_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: two generators share clk/rst. dut_a uses the full
// 640x480 geometry at CLK_DIV=2 for line-level behaviour; dut_b uses a tiny
// 25x13 raster at CLK_DIV=4 so whole frames and the frame wrap fit in a short
// run. A behavioural model predicts every output each clk into a scoreboard.
module tb_vga_timing_gen;

  typedef struct {
    int cdiv;
    int ha;
    int hfp;
    int hs;
    int hbp;
    int va;
    int vfp;
    int vs;
    int vbp;
  } geom_t;

  typedef struct {
    int div;
    int h;
    int v;
    bit pclk;
    bit hs;
    bit vs;
    bit av;
    bit ls;
    bit fs;
  } model_t;

  typedef struct {
    int     dut_id;
    model_t exp;
  } sb_entry_t;

  logic clk = 1'b0;
  logic rst;

  int checks = 0;
  int errors = 0;

  geom_t     geom_a;
  geom_t     geom_b;
  model_t    m_a;
  model_t    m_b;
  sb_entry_t sb_q[$];

  int clk_a, ticks_a, hs_low_a;
  int line_clk_a, line_ticks_a, line_hs_low_a;
  int hs_fall_h_a, hs_rise_h_a, av_fall_h_a, av_rise_h_a;
  int strobes_off_a;
  int clk_b, vs_low_b, pclk_high_b, ls_b;
  int frame_clk_b, frame_vs_low_b, frame_pclk_high_b, frame_ls_b;
  int fs_no_ls_b, v_off_wrap_b, step_no_rise_b;

  logic [9:0] prev_h_a, prev_h_b, prev_v_b;
  logic       prev_hs_a, prev_av_a, prev_pclk_b;

  vga_timing_if vga_a ();
  vga_timing_if vga_b ();

  vga_timing_gen dut_a (
    .clk (clk),
    .rst (rst),
    .vga (vga_a)
  );

  vga_timing_gen #(
    .CLK_DIV  (4),
    .H_ACTIVE (16),
    .H_FP     (2),
    .H_SYNC   (4),
    .H_BP     (3),
    .V_ACTIVE (6),
    .V_FP     (2),
    .V_SYNC   (2),
    .V_BP     (3),
    .SYNC_POL (1'b0)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .vga (vga_b)
  );

  // Free-running system clock, 10 time units per period.
  always #5 clk = ~clk;

  function automatic model_t reset_model();
    model_t m;
    m.div  = 0;
    m.h    = 0;
    m.v    = 0;
    m.pclk = 1'b0;
    m.hs   = 1'b1;
    m.vs   = 1'b1;
    m.av   = 1'b1;
    m.ls   = 1'b0;
    m.fs   = 1'b0;
    return m;
  endfunction

  // One system clock of the reference raster, using plain range arithmetic.
  function automatic model_t step_model(model_t m, geom_t g, bit en);
    model_t n;
    int     ht;
    int     vt;
    ht   = g.ha + g.hfp + g.hs + g.hbp;
    vt   = g.va + g.vfp + g.vs + g.vbp;
    n    = m;
    n.ls = 1'b0;
    n.fs = 1'b0;
    if (!en) return n;
    if (m.div == g.cdiv - 1) begin
      n.div = 0;
      n.h   = (m.h == ht - 1) ? 0 : m.h + 1;
      if (m.h == ht - 1) begin
        n.v  = (m.v == vt - 1) ? 0 : m.v + 1;
        n.ls = 1'b1;
        n.fs = (m.v == vt - 1);
      end
    end else begin
      n.div = m.div + 1;
    end
    n.pclk = (n.div < g.cdiv / 2);
    n.hs   = !((n.h >= g.ha + g.hfp) && (n.h < g.ha + g.hfp + g.hs));
    n.vs   = !((n.v >= g.va + g.vfp) && (n.v < g.va + g.vfp + g.vs));
    n.av   = (n.h < g.ha) && (n.v < g.va);
    return n;
  endfunction

  function automatic logic [31:0] pack_model(model_t m);
    return {6'b0, m.pclk, m.hs, m.vs, m.av, m.ls, m.fs, 10'(m.h), 10'(m.v)};
  endfunction

  function automatic logic [31:0] obs_a();
    return {6'b0, vga_a.pixel_clk, vga_a.h_sync, vga_a.v_sync, vga_a.active_video,
            vga_a.line_start, vga_a.frame_start, vga_a.h_pos, vga_a.v_pos};
  endfunction

  function automatic logic [31:0] obs_b();
    return {6'b0, vga_b.pixel_clk, vga_b.h_sync, vga_b.v_sync, vga_b.active_video,
            vga_b.line_start, vga_b.frame_start, vga_b.h_pos, vga_b.v_pos};
  endfunction

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
  endtask

  task automatic push_expected(input int id, input model_t m);
    sb_entry_t e;
    e.dut_id = id;
    e.exp    = m;
    sb_q.push_back(e);
  endtask

  task automatic drain_scoreboard();
    sb_entry_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.dut_id == 0) check_output("dut_a_outputs", obs_a(), pack_model(e.exp));
      else               check_output("dut_b_outputs", obs_b(), pack_model(e.exp));
    end
  endtask

  task automatic clear_measurements();
    clk_a = 0; ticks_a = 0; hs_low_a = 0;
    line_clk_a = -1; line_ticks_a = -1; line_hs_low_a = -1;
    hs_fall_h_a = -1; hs_rise_h_a = -1; av_fall_h_a = -1; av_rise_h_a = -1;
    strobes_off_a = 0;
    clk_b = 0; vs_low_b = 0; pclk_high_b = 0; ls_b = 0;
    frame_clk_b = -1; frame_vs_low_b = -1; frame_pclk_high_b = -1; frame_ls_b = -1;
    fs_no_ls_b = 0; v_off_wrap_b = 0; step_no_rise_b = 0;
  endtask

  // Per-clk bookkeeping of line and frame measurements taken from the outputs.
  task automatic update_measurements();
    if (!rst) begin
      clear_measurements();
    end else begin
      clk_a++;
      if (vga_a.h_pos != prev_h_a) ticks_a++;
      if (!vga_a.h_sync) hs_low_a++;
      if (!vga_a.h_sync && prev_hs_a) hs_fall_h_a = int'(vga_a.h_pos);
      if (vga_a.h_sync && !prev_hs_a) hs_rise_h_a = int'(vga_a.h_pos);
      if (!vga_a.active_video && prev_av_a) av_fall_h_a = int'(vga_a.h_pos);
      if (vga_a.active_video && !prev_av_a) av_rise_h_a = int'(vga_a.h_pos);
      if (!vga_a.enable && (vga_a.line_start || vga_a.frame_start)) strobes_off_a++;
      if (vga_a.line_start) begin
        line_clk_a    = clk_a;
        line_ticks_a  = ticks_a;
        line_hs_low_a = hs_low_a;
        clk_a = 0; ticks_a = 0; hs_low_a = 0;
      end
      clk_b++;
      if (!vga_b.v_sync) vs_low_b++;
      if (vga_b.pixel_clk) pclk_high_b++;
      if (vga_b.line_start) ls_b++;
      if (vga_b.frame_start && !vga_b.line_start) fs_no_ls_b++;
      if (vga_b.v_pos != prev_v_b && vga_b.h_pos != 10'd0) v_off_wrap_b++;
      if (vga_b.h_pos != prev_h_b && !(vga_b.pixel_clk && !prev_pclk_b)) step_no_rise_b++;
      if (vga_b.frame_start) begin
        frame_clk_b       = clk_b;
        frame_vs_low_b    = vs_low_b;
        frame_pclk_high_b = pclk_high_b;
        frame_ls_b        = ls_b;
        clk_b = 0; vs_low_b = 0; pclk_high_b = 0; ls_b = 0;
      end
    end
    prev_h_a    = vga_a.h_pos;
    prev_hs_a   = vga_a.h_sync;
    prev_av_a   = vga_a.active_video;
    prev_h_b    = vga_b.h_pos;
    prev_v_b    = vga_b.v_pos;
    prev_pclk_b = vga_b.pixel_clk;
  endtask

  // Drive enables, predict the next clk, let it happen and score it.
  task automatic apply_stimulus(input bit en_a, input bit en_b);
    vga_a.enable = en_a;
    vga_b.enable = en_b;
    if (!rst) begin
      m_a = reset_model();
      m_b = reset_model();
    end else begin
      m_a = step_model(m_a, geom_a, en_a);
      m_b = step_model(m_b, geom_b, en_b);
    end
    push_expected(0, m_a);
    push_expected(1, m_b);
    @(posedge clk);
    #1;
    drain_scoreboard();
    update_measurements();
  endtask

  task automatic wait_a_hpos(input int target, input int budget);
    int n;
    n = 0;
    while (vga_a.h_pos != 10'(target) && n < budget) begin
      apply_stimulus(1'b1, 1'b1);
      n++;
    end
    check_output("wait_a_hpos", 32'(vga_a.h_pos), 32'(target));
  endtask

  task automatic wait_a_ls(input int budget);
    int n;
    n = 0;
    do begin
      apply_stimulus(1'b1, 1'b1);
      n++;
    end while (!vga_a.line_start && n < budget);
    check_output("wait_a_line_start", 32'(vga_a.line_start), 32'd1);
  endtask

  task automatic wait_b_fs(input int budget);
    int n;
    n = 0;
    do begin
      apply_stimulus(1'b1, 1'b1);
      n++;
    end while (!vga_b.frame_start && n < budget);
    check_output("wait_b_frame_start", 32'(vga_b.frame_start), 32'd1);
  endtask

  task automatic wait_b_pos(input int h, input int v, input int budget);
    int n;
    n = 0;
    while ((vga_b.h_pos != 10'(h) || vga_b.v_pos != 10'(v)) && n < budget) begin
      apply_stimulus(1'b1, 1'b1);
      n++;
    end
    check_output("wait_b_pos", {12'b0, vga_b.h_pos, vga_b.v_pos}, {12'b0, 10'(h), 10'(v)});
  endtask

  task automatic check_b_frame(input string tag);
    check_output({tag, "_clk"},       32'(frame_clk_b),       32'd1300);
    check_output({tag, "_line_cnt"},  32'(frame_ls_b),        32'd13);
    check_output({tag, "_vsync_low"}, 32'(frame_vs_low_b),    32'd200);
    check_output({tag, "_pclk_high"}, 32'(frame_pclk_high_b), 32'd650);
  endtask

  // Directed sequence: reset, line timing, enable gating, async reset, frame.
  initial begin
    int n;
    geom_a = '{2, 640, 16, 96, 48, 480, 10, 2, 33};
    geom_b = '{4, 16, 2, 4, 3, 6, 2, 2, 3};
    clear_measurements();
    rst          = 1'b1;
    vga_a.enable = 1'b1;
    vga_b.enable = 1'b1;
    m_a = reset_model();
    m_b = reset_model();

    #1 rst = 1'b0;
    #1;
    push_expected(0, m_a);
    push_expected(1, m_b);
    drain_scoreboard();
    apply_stimulus(1'b1, 1'b1);
    apply_stimulus(1'b1, 1'b1);
    #3 rst = 1'b1;
    $display("[TB] reset released");

    wait_a_ls(1700);
    check_output("line0_clk",        32'(line_clk_a),    32'd1600);
    check_output("line0_ticks",      32'(line_ticks_a),  32'd800);
    check_output("line0_hsync_low",  32'(line_hs_low_a), 32'd192);
    check_output("line0_hsync_fall", 32'(hs_fall_h_a),   32'd656);
    check_output("line0_hsync_rise", 32'(hs_rise_h_a),   32'd752);
    check_output("line0_av_fall",    32'(av_fall_h_a),   32'd640);
    check_output("line0_av_rise",    32'(av_rise_h_a),   32'd0);
    apply_stimulus(1'b1, 1'b1);
    check_output("line_start_width", 32'(vga_a.line_start), 32'd0);

    wait_a_hpos(100, 300);
    for (int i = 0; i < 37; i++) apply_stimulus(1'b0, 1'b1);
    check_output("freeze_pos",     {12'b0, vga_a.h_pos, vga_a.v_pos}, {12'b0, 10'd100, 10'd1});
    check_output("freeze_levels",  {29'b0, vga_a.pixel_clk, vga_a.h_sync, vga_a.active_video},
                 32'b111);
    check_output("freeze_strobes", 32'(strobes_off_a), 32'd0);

    wait_a_ls(1800);
    check_output("line1_ticks",     32'(line_ticks_a),  32'd800);
    check_output("line1_clk",       32'(line_clk_a),    32'd1637);
    check_output("line1_hsync_low", 32'(line_hs_low_a), 32'd192);

    wait_a_hpos(300, 700);
    rst = 1'b0;
    #1;
    m_a = reset_model();
    m_b = reset_model();
    push_expected(0, m_a);
    push_expected(1, m_b);
    drain_scoreboard();
    apply_stimulus(1'b1, 1'b1);
    apply_stimulus(1'b1, 1'b1);
    #3 rst = 1'b1;
    $display("[TB] mid-line reset released");

    wait_b_fs(1400);
    check_b_frame("frame0");

    wait_b_pos(24, 12, 1400);
    n = 0;
    do begin
      apply_stimulus(1'b1, 1'b1);
      n++;
    end while (vga_b.h_pos == 10'd24 && n < 8);
    check_output("wrap_boundary",
                 32'({vga_b.active_video, vga_b.v_sync, vga_b.h_sync, vga_b.frame_start,
                      vga_b.line_start, vga_b.h_pos, vga_b.v_pos}),
                 32'({5'b11111, 20'd0}));
    check_b_frame("frame1");
    check_output("fs_without_ls",     32'(fs_no_ls_b),     32'd0);
    check_output("v_step_off_wrap",   32'(v_off_wrap_b),   32'd0);
    check_output("h_step_no_pclk_up", 32'(step_no_rise_b), 32'd0);
    apply_stimulus(1'b1, 1'b1);
    check_output("frame_start_width", 32'(vga_b.frame_start), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
